pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Hazard and sequencing controller for the 3-stage processor pipeline: fetch/PC, decode register (reg1) and execute/writeback register (reg2).
- Issues stall and clear strobes to the pipeline registers.
- Redirects the PC on absolute and relative jumps.
- Waits on data memory for loads.
- Inserts a load-use bubble.
- Freezes the core on halt until a resume pulse.

Parameters:
A_BITS, 10, address/PC width; also width of jump values
MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready before forcing completion and flagging an error

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  EX stage holds a real instruction (not a bubble)
ex_halt_op  in  1  EX instruction is HALT
ex_jmp_op  in  1  EX instruction is a jump
ex_jmp_relative_op  in  1  jump is PC-relative
ex_jmp_val  in  A_BITS  absolute target, or signed offset if relative
ex_pc  in  A_BITS  PC of the EX instruction
ex_read  in  1  EX instruction is a memory load
ex_dest  in  3  destination register of the EX instruction
id_src1  in  3  decode source register 1
id_src2  in  3  decode source register 2
id_use  in  2  bit0/bit1: id_src1/id_src2 actually read
mem_ready  in  1  data memory returns load data this cycle
resume  in  1  leave HALTED
pc_stall  out  1  hold PC
id_stall  out  1  hold reg1
ex_stall  out  1  hold reg2 inputs / EX operands
id_clr  out  1  clear reg1 at next edge
ex_clr  out  1  clear reg2 at next edge (bubble)
pc_load  out  1  load PC with pc_load_val at next edge
pc_load_val  out  A_BITS  jump target
mem_req  out  1  load request active
halted  out  1  core frozen
mem_err  out  1  sticky: a load timed out

Behaviour:
- Reset state is RUN. Timeout counter, mem_err and halted clear to 0. All strobes are 0 during and after reset until inputs demand otherwise. Reset mid-wait or mid-halt returns to RUN immediately.
- FSM states: RUN, MEM_WAIT, LD_STALL, HALTED. Outputs are combinational from state and current inputs (Mealy); state, counter and mem_err are registered.
- Event priority in RUN, evaluated only when ex_valid=1:
  - Priority order: halt > jump > load > none.
  - Event bits are ignored when ex_valid=0.
- RUN, halt: pc_stall=id_stall=ex_stall=1. Next state HALTED.
- RUN, jump: pc_load=1, id_clr=1, ex_clr=1; no stall.
  - Absolute jump: pc_load_val=ex_jmp_val.
  - Relative jump: pc_load_val=ex_pc+ex_jmp_val, modulo 2^A_BITS (wraps, no overflow flag).
  - Stays in RUN. Results in exactly 2 squashed slots.
- RUN, load: mem_req=1.
  - If mem_ready=1 the same cycle, the load completes with no stall.
  - Otherwise pc_stall=id_stall=ex_stall=1, ex_clr=1, counter<=1, next state MEM_WAIT.
- MEM_WAIT: mem_req=1, all three stalls=1, ex_clr=1. Counter increments each cycle.
  - Completion occurs when mem_ready=1, or when counter==MEM_TIMEOUT; on timeout mem_err<=1.
  - In the completion cycle stalls and ex_clr drop to 0, so the load advances.
- Load completion (from RUN or MEM_WAIT): hazard = (id_use[0]&&id_src1==ex_dest) || (id_use[1]&&id_src2==ex_dest), with ex_dest!=0.
  - Hazard: next state LD_STALL.
  - No hazard: next state RUN.
- LD_STALL: exactly 1 cycle. pc_stall=id_stall=1, ex_clr=1 (bubble into EX). Next state RUN.
- HALTED: halted=1, all stalls=1, no clr, no pc_load.
  - resume=1: next state RUN, and id_clr=1 in that cycle so the HALT is not re-executed.
  - resume ignored in all other states.
- mem_err: sticky; cleared only by rst.
- Simultaneous mem_ready and timeout in the same cycle: treated as normal completion, mem_err unchanged.

Optional Feature:
STALL_COUNT_EN
- Defined: adds output stall_cycles [15:0]. Increments every cycle pc_stall=1 and state!=HALTED; saturates at 16'hFFFF; cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Absolute jump: ex_valid=1, ex_jmp_op=1, ex_jmp_val=0x120 -> same cycle pc_load=1, pc_load_val=0x120, id_clr=ex_clr=1, no stalls.
- Relative wrap: ex_pc=0x3FE, ex_jmp_val=0x005, relative=1 -> pc_load_val=0x003.
- Load with mem_ready after 3 cycles: MEM_WAIT for 3 cycles with stalls and ex_clr=1, release on the ready cycle. id_src1==ex_dest=3 with id_use=01 -> one LD_STALL cycle, then RUN.
- Timeout: ex_read=1, mem_ready held 0 -> release at cycle MEM_TIMEOUT=15, mem_err=1 and remains 1 until rst.
- Halt and jump in the same EX instruction -> HALTED, pc_load=0. halted=1 held for 10 cycles; resume pulse -> RUN with id_clr=1 that cycle.
- rst asserted during MEM_WAIT -> next cycle state RUN, mem_req=0, counter and mem_err 0. Any event with ex_valid=0 -> all outputs 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and pipeline_ctrl (slave).
// stall_cycles is not carried here; it is a plain port enabled by STALL_COUNT_EN.
interface pipeline_ctrl_if #(
  parameter int A_BITS = 10
);
  logic              ex_valid;
  logic              ex_halt_op;
  logic              ex_jmp_op;
  logic              ex_jmp_relative_op;
  logic [A_BITS-1:0] ex_jmp_val;
  logic [A_BITS-1:0] ex_pc;
  logic              ex_read;
  logic [2:0]        ex_dest;
  logic [2:0]        id_src1;
  logic [2:0]        id_src2;
  logic [1:0]        id_use;
  logic              mem_ready;
  logic              resume;

  logic              pc_stall;
  logic              id_stall;
  logic              ex_stall;
  logic              id_clr;
  logic              ex_clr;
  logic              pc_load;
  logic [A_BITS-1:0] pc_load_val;
  logic              mem_req;
  logic              halted;
  logic              mem_err;

  modport master (
    output ex_valid, ex_halt_op, ex_jmp_op, ex_jmp_relative_op, ex_jmp_val, ex_pc,
           ex_read, ex_dest, id_src1, id_src2, id_use, mem_ready, resume,
    input  pc_stall, id_stall, ex_stall, id_clr, ex_clr, pc_load, pc_load_val,
           mem_req, halted, mem_err
  );

  modport slave (
    input  ex_valid, ex_halt_op, ex_jmp_op, ex_jmp_relative_op, ex_jmp_val, ex_pc,
           ex_read, ex_dest, id_src1, id_src2, id_use, mem_ready, resume,
    output pc_stall, id_stall, ex_stall, id_clr, ex_clr, pc_load, pc_load_val,
           mem_req, halted, mem_err
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 3-stage pipeline (jumps, load waits, load-use bubble, halt).
// Define STALL_COUNT_EN to add the saturating stall_cycles counter output.
module pipeline_ctrl #(
  parameter int A_BITS      = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]    stall_cycles
`endif
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, LD_STALL, HALTED} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              mem_err_q, mem_err_nxt;
  logic              hazard;
  logic              timeout;
  logic [A_BITS-1:0] jmp_target;

  always_comb begin
    hazard = (bus.ex_dest != 3'd0) &&
             ((bus.id_use[0] && (bus.id_src1 == bus.ex_dest)) ||
              (bus.id_use[1] && (bus.id_src2 == bus.ex_dest)));
    timeout    = (cnt == CW'(MEM_TIMEOUT));
    jmp_target = bus.ex_jmp_relative_op ? (bus.ex_pc + bus.ex_jmp_val) : bus.ex_jmp_val;
  end

  // Mealy strobes; everything is held at 0 while rst is asserted.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    mem_err_nxt     = mem_err_q;
    bus.pc_stall    = 1'b0;
    bus.id_stall    = 1'b0;
    bus.ex_stall    = 1'b0;
    bus.id_clr      = 1'b0;
    bus.ex_clr      = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_load_val = '0;
    bus.mem_req     = 1'b0;
    bus.halted      = 1'b0;
    bus.mem_err     = mem_err_q;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (bus.ex_valid) begin
            if (bus.ex_halt_op) begin
              bus.pc_stall = 1'b1;
              bus.id_stall = 1'b1;
              bus.ex_stall = 1'b1;
              state_nxt    = HALTED;
            end else if (bus.ex_jmp_op) begin
              bus.pc_load     = 1'b1;
              bus.pc_load_val = jmp_target;
              bus.id_clr      = 1'b1;
              bus.ex_clr      = 1'b1;
            end else if (bus.ex_read) begin
              bus.mem_req = 1'b1;
              if (bus.mem_ready) begin
                state_nxt = hazard ? LD_STALL : RUN;
              end else begin
                bus.pc_stall = 1'b1;
                bus.id_stall = 1'b1;
                bus.ex_stall = 1'b1;
                bus.ex_clr   = 1'b1;
                cnt_nxt      = CW'(1);
                state_nxt    = MEM_WAIT;
              end
            end
          end
        end
        MEM_WAIT: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready || timeout) begin
            // A simultaneous ready wins over the timeout and is not an error.
            if (!bus.mem_ready) mem_err_nxt = 1'b1;
            state_nxt = hazard ? LD_STALL : RUN;
          end else begin
            bus.pc_stall = 1'b1;
            bus.id_stall = 1'b1;
            bus.ex_stall = 1'b1;
            bus.ex_clr   = 1'b1;
            cnt_nxt      = cnt + CW'(1);
          end
        end
        LD_STALL: begin
          bus.pc_stall = 1'b1;
          bus.id_stall = 1'b1;
          bus.ex_clr   = 1'b1;
          state_nxt    = RUN;
        end
        HALTED: begin
          bus.halted   = 1'b1;
          bus.pc_stall = 1'b1;
          bus.id_stall = 1'b1;
          bus.ex_stall = 1'b1;
          if (bus.resume) begin
            bus.id_clr = 1'b1;
            state_nxt  = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_err_q <= mem_err_nxt;
    end
  end

`ifdef STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (bus.pc_stall && (state != HALTED) && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif
endmodule
